// File: rtl/tqvp_sprite_renderer_if.sv
// Signal bundle between the video controller / object and bitmap stores
// (master side) and the 1bpp sprite renderer (slave side).
interface tqvp_sprite_renderer_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       visible;
    logic [5:0] bg_rgb;
    logic [9:0] obj_x;
    logic [9:0] obj_y;
    logic [5:0] obj_color;
    logic       obj_enable;
    logic [4:0] bmp_addr;
    logic [7:0] bmp_data;
    logic       clr_collision;
    logic [5:0] rgb_out;
    logic       sprite_hit;
    logic       collision;

    modport master (
        output pix_x, pix_y, visible, bg_rgb,
        output obj_x, obj_y, obj_color, obj_enable,
        output bmp_data, clr_collision,
        input  bmp_addr, rgb_out, sprite_hit, collision
    );

    modport slave (
        input  pix_x, pix_y, visible, bg_rgb,
        input  obj_x, obj_y, obj_color, obj_enable,
        input  bmp_data, clr_collision,
        output bmp_addr, rgb_out, sprite_hit, collision
    );
endinterface

// File: rtl/tqvp_sprite_renderer.sv
// Per-scanline 1bpp sprite engine. During horizontal blank it latches the
// object fields for the coming line and fetches one bitmap row; during active
// video it shifts that row out over the background colour, flags opaque
// sprite pixels and keeps a sticky sprite/background collision flag.
module tqvp_sprite_renderer #(
    parameter int SPRITE_H = 16,
    parameter int SCALE    = 1,
    parameter int V_ACTIVE = 480
) (
    input  logic                         clk,
    input  logic                         rst,
    tqvp_sprite_renderer_if.slave        bus
);
    // SCALE is restricted to 1, 2 or 4, so the divide is a right shift.
    localparam int         SCALE_SHIFT = (SCALE >= 4) ? 2 : ((SCALE >= 2) ? 1 : 0);
    localparam int         SPAN        = 8 * SCALE;
    localparam logic [9:0] LAST_LINE   = 10'(V_ACTIVE - 1);
    localparam logic [1:0] SUB_LAST    = 2'(SCALE - 1);
    localparam logic [5:0] SPAN_LAST   = 6'(SPAN - 1);
    localparam logic [9:0] ROWS        = 10'(SPRITE_H);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        ARMED,
        DRAW
    } state_t;

    state_t     state_q, state_d;
    logic       visible_q;
    logic [9:0] next_line_q, next_line_d;
    logic [9:0] obj_x_q, obj_x_d;
    logic [9:0] obj_y_q, obj_y_d;
    logic [5:0] color_q, color_d;
    logic       enable_q, enable_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] sub_q, sub_d;
    logic [5:0] span_q, span_d;
    logic [5:0] rgb_q, rgb_d;
    logic       hit_q, hit_d;
    logic       coll_q, coll_d;

    logic       vis_fall;
    logic       start_hit;
    logic       draw_now;
    logic       opaque;
    logic       load_shadow;
    logic       in_range;
    logic [9:0] line_diff;
    logic [9:0] row;

    // Start of horizontal blank, and the pixel where the sprite begins.
    assign vis_fall  = visible_q && !bus.visible;
    assign start_hit = bus.visible && (bus.pix_x == obj_x_q);

    // The first sprite pixel is emitted in the same cycle the FSM leaves
    // ARMED, so the output register always reflects the pixel column it was
    // sampled with (including a sprite at column 0).
    assign draw_now = (state_q == DRAW) || ((state_q == ARMED) && start_hit);
    assign opaque   = draw_now && shreg_q[7];

    // Bitmap row for the line being prefetched; wrapped subtraction plus the
    // explicit line compare keeps sprites near the bottom from wrapping to line 0.
    always_comb begin
        line_diff = next_line_q - obj_y_q;
        row       = line_diff >> SCALE_SHIFT;
        in_range  = enable_q && (next_line_q >= obj_y_q) && (row < ROWS);
    end

    assign bus.bmp_addr = ((state_q == ADDR) && in_range) ? row[4:0] : 5'd0;

    // Fetch / arm / draw sequencing and shadow loading.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        sub_d       = sub_q;
        span_d      = span_q;
        load_shadow = 1'b0;

        case (state_q)
            IDLE: begin
                if (vis_fall) begin
                    load_shadow = 1'b1;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                state_d = LATCH;
            end
            LATCH: begin
                shreg_d = in_range ? bus.bmp_data : 8'h00;
                sub_d   = 2'd0;
                span_d  = 6'd0;
                state_d = ARMED;
            end
            ARMED, DRAW: begin
                if (vis_fall) begin
                    // Right-edge clip: abandon the row and fetch the next line.
                    load_shadow = 1'b1;
                    state_d     = ADDR;
                end else if (draw_now && bus.visible) begin
                    state_d = DRAW;
                    if (sub_q == SUB_LAST) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        sub_d   = 2'd0;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                    if (span_q == SPAN_LAST) begin
                        state_d = IDLE;
                    end else begin
                        span_d = span_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line shadows: object fields frozen at start of hblank for the next line.
    always_comb begin
        next_line_d = next_line_q;
        obj_x_d     = obj_x_q;
        obj_y_d     = obj_y_q;
        color_d     = color_q;
        enable_d    = enable_q;
        if (load_shadow) begin
            next_line_d = (bus.pix_y == LAST_LINE) ? 10'd0 : (bus.pix_y + 10'd1);
            obj_x_d     = bus.obj_x;
            obj_y_d     = bus.obj_y;
            color_d     = bus.obj_color;
            enable_d    = bus.obj_enable;
        end
    end

    // Compositing and collision for the pixel sampled this cycle.
    always_comb begin
        rgb_d  = bus.visible ? (opaque ? color_q : bus.bg_rgb) : 6'h00;
        hit_d  = bus.visible && opaque;
        // A set in the same cycle as a clear wins.
        coll_d = (coll_q && !bus.clr_collision) ||
                 (bus.visible && opaque && (bus.bg_rgb != 6'h00));
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            visible_q   <= 1'b0;
            next_line_q <= 10'd0;
            obj_x_q     <= 10'd0;
            obj_y_q     <= 10'd0;
            color_q     <= 6'h00;
            enable_q    <= 1'b0;
            shreg_q     <= 8'h00;
            sub_q       <= 2'd0;
            span_q      <= 6'd0;
            rgb_q       <= 6'h00;
            hit_q       <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            visible_q   <= bus.visible;
            next_line_q <= next_line_d;
            obj_x_q     <= obj_x_d;
            obj_y_q     <= obj_y_d;
            color_q     <= color_d;
            enable_q    <= enable_d;
            shreg_q     <= shreg_d;
            sub_q       <= sub_d;
            span_q      <= span_d;
            rgb_q       <= rgb_d;
            hit_q       <= hit_d;
            coll_q      <= coll_d;
        end
    end

    assign bus.rgb_out    = rgb_q;
    assign bus.sprite_hit = hit_q;
    assign bus.collision  = coll_q;

endmodule

// File: tb/tb_tqvp_sprite_renderer.sv
// Directed bench for the sprite renderer: one SCALE=1 instance and one
// SCALE=2 instance share video timing; each line's outputs are captured per
// pixel column and compared with hand-computed values.
module tb_tqvp_sprite_renderer;
    localparam int H_VIS   = 640;
    localparam int H_BLANK = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tqvp_sprite_renderer_if bus0 ();
    tqvp_sprite_renderer_if bus1 ();

    tqvp_sprite_renderer #(.SPRITE_H(16), .SCALE(1), .V_ACTIVE(480)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    tqvp_sprite_renderer #(.SPRITE_H(16), .SCALE(2), .V_ACTIVE(480)) dut_x2 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.pix_x         = bus0.pix_x;
    assign bus1.pix_y         = bus0.pix_y;
    assign bus1.visible       = bus0.visible;
    assign bus1.bg_rgb        = bus0.bg_rgb;
    assign bus1.clr_collision = bus0.clr_collision;

    // Bitmap stores with one-cycle registered read.
    logic [7:0] bmp0 [0:31];
    logic [7:0] bmp1 [0:31];
    always @(posedge clk) begin
        bus0.bmp_data <= bmp0[bus0.bmp_addr];
        bus1.bmp_data <= bmp1[bus1.bmp_addr];
    end

    logic [5:0] rgb0 [0:H_VIS-1];
    logic       hit0 [0:H_VIS-1];
    logic       col0 [0:H_VIS-1];
    logic [5:0] rgb1 [0:H_VIS-1];
    logic [4:0] addr_seen;

    logic [5:0] pat_bg3 [0:7];
    logic [5:0] pat_bg0 [0:7];
    logic       pat_hit [0:7];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rgb0(input string tag, input int x, input logic [5:0] exp);
        check_eq($sformatf("%s rgb_out[x=%0d]", tag, x), int'(rgb0[x]), int'(exp));
    endtask

    task automatic chk_hit0(input string tag, input int x, input logic exp);
        check_eq($sformatf("%s sprite_hit[x=%0d]", tag, x), int'(hit0[x]), int'(exp));
    endtask

    task automatic chk_col0(input string tag, input int x, input logic exp);
        check_eq($sformatf("%s collision[x=%0d]", tag, x), int'(col0[x]), int'(exp));
    endtask

    task automatic chk_rgb1(input string tag, input int x, input logic [5:0] exp);
        check_eq($sformatf("%s x2 rgb_out[x=%0d]", tag, x), int'(rgb1[x]), int'(exp));
    endtask

    // One scanline (active + hblank) with optional mid-line events.
    task automatic run_line(input int y, input logic [5:0] bg, input int clr_at,
                            input int rst_at, input int newx_at, input logic [9:0] newx);
        addr_seen = 5'd0;
        for (int p = 0; p < H_VIS + H_BLANK; p++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            if (p > 0 && p <= H_VIS) begin
                rgb0[p-1] = bus0.rgb_out;
                hit0[p-1] = bus0.sprite_hit;
                col0[p-1] = bus0.collision;
                rgb1[p-1] = bus1.rgb_out;
            end
            if (p > H_VIS) addr_seen = addr_seen | bus0.bmp_addr;
            bus0.pix_x         = 10'(p);
            bus0.pix_y         = 10'(y);
            bus0.visible       = (p < H_VIS);
            bus0.bg_rgb        = bg;
            bus0.clr_collision = (p == clr_at);
            if (p == newx_at) bus0.obj_x = newx;
            if (p == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq($sformatf("async reset L%0d x=%0d", y, p), int'(bus0.rgb_out), 0);
            end
        end
    endtask

    task automatic line(input int y, input logic [5:0] bg);
        run_line(y, bg, -1, -1, -1, 10'd0);
    endtask

    initial begin
        pat_bg3 = '{6'h30, 6'h03, 6'h30, 6'h03, 6'h03, 6'h30, 6'h03, 6'h30};
        pat_bg0 = '{6'h30, 6'h00, 6'h30, 6'h00, 6'h00, 6'h30, 6'h00, 6'h30};
        pat_hit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 32; i++) begin
            bmp0[i] = 8'hFF;
            bmp1[i] = 8'hFF;
        end
        bmp0[0] = 8'hA5;
        bmp1[1] = 8'h00;

        rst                = 1'b1;
        bus0.pix_x         = 10'd5;
        bus0.pix_y         = 10'd0;
        bus0.visible       = 1'b1;
        bus0.bg_rgb        = 6'h03;
        bus0.clr_collision = 1'b0;
        bus0.obj_x         = 10'd100;
        bus0.obj_y         = 10'd50;
        bus0.obj_color     = 6'h30;
        bus0.obj_enable    = 1'b1;
        bus1.obj_x         = 10'd100;
        bus1.obj_y         = 10'd10;
        bus1.obj_color     = 6'h30;
        bus1.obj_enable    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset rgb_out", int'(bus0.rgb_out), 0);
        check_eq("reset sprite_hit", int'(bus0.sprite_hit), 0);
        check_eq("reset collision", int'(bus0.collision), 0);
        check_eq("reset bmp_addr", int'(bus0.bmp_addr), 0);
        check_eq("reset x2 rgb_out", int'(bus1.rgb_out), 0);
        bus0.visible = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // SCALE=2: rows FF,00 at obj_y=10
        line(9, 6'h03);
        line(10, 6'h03);
        chk_rgb1("L10", 99, 6'h03);
        chk_rgb1("L10", 100, 6'h30);
        chk_rgb1("L10", 107, 6'h30);
        chk_rgb1("L10", 108, 6'h30);
        chk_rgb1("L10", 115, 6'h30);
        chk_rgb1("L10", 116, 6'h03);
        line(11, 6'h03);
        chk_rgb1("L11", 100, 6'h30);
        chk_rgb1("L11", 115, 6'h30);
        line(12, 6'h03);
        chk_rgb1("L12", 100, 6'h03);
        chk_rgb1("L12", 108, 6'h03);
        line(13, 6'h03);
        chk_rgb1("L13", 100, 6'h03);
        chk_rgb1("L13", 115, 6'h03);

        // Basic row A5 at (100,50); bg=0 never collides
        line(49, 6'h03);
        chk_rgb0("L49", 100, 6'h03);
        chk_hit0("L49", 100, 1'b0);
        chk_col0("L49", 639, 1'b0);
        line(50, 6'h00);
        for (int i = 0; i < 8; i++) chk_rgb0("L50 bg0", 100 + i, pat_bg0[i]);
        chk_col0("L50 bg0", 639, 1'b0);
        line(49, 6'h00);
        chk_rgb0("L49 bg0 row1", 104, 6'h30);
        chk_col0("L49 bg0 row1", 639, 1'b0);
        run_line(50, 6'h03, 200, -1, -1, 10'd0);
        for (int i = 0; i < 8; i++) begin
            chk_rgb0("L50", 100 + i, pat_bg3[i]);
            chk_hit0("L50", 100 + i, pat_hit[i]);
        end
        chk_rgb0("L50", 99, 6'h03);
        chk_rgb0("L50", 108, 6'h03);
        chk_col0("L50", 99, 1'b0);
        chk_col0("L50", 100, 1'b1);
        chk_col0("L50 before clr", 199, 1'b1);
        chk_col0("L50 after clr", 200, 1'b0);
        chk_col0("L50", 639, 1'b0);
        check_eq("fetch addr for line 51", int'(addr_seen), 1);

        // Clear pulse on an overlapping pixel: set wins
        run_line(51, 6'h03, 100, -1, -1, 10'd0);
        chk_col0("L51", 99, 1'b0);
        chk_col0("L51 clr+set", 100, 1'b1);
        chk_rgb0("L51", 100, 6'h30);

        // obj_x changed mid-line takes effect on the next line
        run_line(52, 6'h03, -1, -1, 50, 10'd200);
        chk_rgb0("L52", 100, 6'h30);
        chk_rgb0("L52", 107, 6'h30);
        chk_rgb0("L52", 200, 6'h03);
        line(53, 6'h03);
        chk_rgb0("L53", 100, 6'h03);
        chk_rgb0("L53", 200, 6'h30);
        chk_rgb0("L53", 207, 6'h30);

        // Reset pulse mid-draw, then a clean line
        run_line(54, 6'h03, -1, 203, -1, 10'd0);
        chk_rgb0("L54", 202, 6'h30);
        chk_col0("L54", 202, 1'b1);
        chk_rgb0("L54 in reset", 203, 6'h00);
        chk_hit0("L54 in reset", 203, 1'b0);
        chk_col0("L54 in reset", 203, 1'b0);
        chk_rgb0("L54 after reset", 204, 6'h03);
        line(55, 6'h03);
        chk_rgb0("L55", 199, 6'h03);
        chk_rgb0("L55", 200, 6'h30);
        chk_rgb0("L55", 207, 6'h30);
        chk_rgb0("L55", 208, 6'h03);

        // Bottom edge of the sprite: row 15 drawn, row 16 transparent
        line(64, 6'h03);
        check_eq("fetch addr for line 65", int'(addr_seen), 15);
        line(65, 6'h03);
        chk_rgb0("L65 row15", 200, 6'h30);
        check_eq("fetch addr for line 66", int'(addr_seen), 0);
        line(66, 6'h03);
        chk_rgb0("L66 row16", 200, 6'h03);
        chk_hit0("L66 row16", 200, 1'b0);

        // Right-edge clip at x=636
        bus0.obj_x = 10'd636;
        bus0.obj_y = 10'd477;
        line(477, 6'h03);
        check_eq("fetch addr for line 478", int'(addr_seen), 1);
        line(478, 6'h03);
        chk_rgb0("L478", 635, 6'h03);
        chk_rgb0("L478", 636, 6'h30);
        chk_rgb0("L478", 639, 6'h30);
        chk_hit0("L478", 636, 1'b1);
        chk_hit0("L478", 639, 1'b1);
        line(479, 6'h03);
        chk_rgb0("L479", 636, 6'h30);
        chk_rgb0("L479", 639, 6'h30);
        check_eq("fetch addr for line 0", int'(addr_seen), 0);
        line(0, 6'h03);
        chk_rgb0("L0", 0, 6'h03);
        chk_rgb0("L0", 636, 6'h03);
        chk_hit0("L0", 639, 1'b0);

        // Sprite at x=0 straddling the last visible line
        bus0.obj_x = 10'd0;
        bus0.obj_y = 10'd470;
        line(469, 6'h03);
        line(470, 6'h03);
        for (int i = 0; i < 8; i++) chk_rgb0("L470", i, pat_bg3[i]);
        chk_rgb0("L470", 8, 6'h03);
        for (int y = 471; y <= 479; y++) begin
            line(y, 6'h03);
            chk_rgb0($sformatf("L%0d", y), 0, 6'h30);
            chk_rgb0($sformatf("L%0d", y), 7, 6'h30);
        end
        line(0, 6'h03);
        chk_rgb0("L0 no wrap", 0, 6'h03);
        chk_hit0("L0 no wrap", 0, 1'b0);

        // Disabled object: background everywhere
        bus0.obj_x      = 10'd100;
        bus0.obj_y      = 10'd50;
        bus0.obj_enable = 1'b0;
        line(49, 6'h15);
        line(50, 6'h15);
        for (int x = 0; x < H_VIS; x++) chk_rgb0("L50 disabled", x, 6'h15);
        chk_hit0("L50 disabled", 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
